// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calc datapath.
//   CALC_WIDTH  : operand width of the arithmetic units
//   CALC_RES_W  : result width (operand width + 2)
//   state_t     : sequencing states of the bit-serial units
package calc_pkg;
  localparam int CALC_WIDTH = 4;
  localparam int CALC_RES_W = CALC_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ABS   = 2'd2,
    FIN   = 2'd3
  } state_t;
endpackage

// File: rtl/sub_serial_if.sv
// sub_serial_if: START/BUSY/DONE handshake bundle of the bit-serial subtractor.
//   start, a_data, b_data : request and operands (controller -> subtractor)
//   busy, done, sub_data  : status and result     (subtractor -> controller)
//   neg                   : result-negative flag, only when SUB_ABS_EN is defined
// Modports: master = calc controller, slave = subtractor.
interface sub_serial_if #(parameter int WIDTH = calc_pkg::CALC_WIDTH) ();
  logic             start;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             busy;
  logic             done;
  logic [WIDTH+1:0] sub_data;
`ifdef SUB_ABS_EN
  logic             neg;

  modport master (output start, a_data, b_data, input busy, done, sub_data, neg);
  modport slave  (input start, a_data, b_data, output busy, done, sub_data, neg);
`else
  modport master (output start, a_data, b_data, input busy, done, sub_data);
  modport slave  (input start, a_data, b_data, output busy, done, sub_data);
`endif
endinterface

// File: rtl/fullsubtractor.sv
// fullsubtractor: 1-bit combinational subtract cell, counterpart of fulladder.
//   a, b : minuend / subtrahend bits
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/sub_serial.sv
// sub_serial: bit-serial unsigned subtractor, A - B one bit per clock, LSB first,
// with the ripple borrow held in a register.
//   CLK  : clock (rising edge)
//   RST  : synchronous active-high reset
//   bus  : sub_serial_if.slave (start/a_data/b_data in; busy/done/sub_data[/neg] out)
// Optional feature macro SUB_ABS_EN: adds one ABS cycle that returns |A-B|
// zero-extended in sub_data plus a neg flag. Without it, sub_data is the
// (WIDTH+2)-bit two's-complement difference.
module sub_serial
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input logic        CLK,
  input logic        RST,
  sub_serial_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             d;
  logic             bo;
  logic             last;
  logic [WIDTH-1:0] diff;

  fullsubtractor u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));
  // Result register with this cycle's difference bit shifted in at the top;
  // after WIDTH shifts bit 0 has reached the LSB.
  assign diff = {d, res[WIDTH-1:1]};

`ifdef SUB_ABS_EN
  logic [WIDTH:0] raw;
  logic [WIDTH:0] mag;
  assign raw = {borrow, res};
  assign mag = borrow ? (~raw + 1'b1) : raw;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      res          <= '0;
      borrow       <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sub_data <= '0;
`ifdef SUB_ABS_EN
      bus.neg      <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        // FIN is also a ready state so operations can run back-to-back.
        IDLE, FIN: begin
          if (bus.start) begin
            a_sr     <= bus.a_data;
            b_sr     <= bus.b_data;
            borrow   <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res    <= diff;
          borrow <= bo;
          cnt    <= cnt + 1'b1;
          if (last) begin
`ifdef SUB_ABS_EN
            state        <= ABS;
`else
            // Final borrow is the sign; it fills both upper result bits.
            state        <= FIN;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.sub_data <= {bo, bo, diff};
`endif
          end
        end
`ifdef SUB_ABS_EN
        ABS: begin
          state        <= FIN;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          bus.neg      <= borrow;
          bus.sub_data <= {1'b0, mag};
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed bench for sub_serial. A cycle model derived from the
// arithmetic (A-B as integers, fixed latency) is compared against the DUT on
// every cycle; directed operations also check hand-computed literals.
// Honors SUB_ABS_EN in the same way as the design.
module tb_sub_serial;
  import calc_pkg::*;

`ifdef SUB_ABS_EN
  localparam int LAT_CYC = CALC_WIDTH + 2;
`else
  localparam int LAT_CYC = CALC_WIDTH + 1;
`endif

  logic CLK;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  sub_serial_if #(.WIDTH(CALC_WIDTH)) bus ();

  sub_serial #(.WIDTH(CALC_WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age = edges since the operation was accepted, -1 when ready.
  int                  age = -1;
  logic                m_busy = 1'b0;
  logic                m_done = 1'b0;
  logic [CALC_RES_W-1:0] m_data = '0;
  logic                m_neg = 1'b0;
  logic [CALC_RES_W-1:0] m_pend_data;
  logic                m_pend_neg;

  always @(posedge CLK) begin
    int dv;
    if (RST) begin
      age = -1; m_busy = 0; m_done = 0; m_data = '0; m_neg = 0;
    end else begin
      m_done = 0;
      if (age >= 0) begin
        age++;
        if (age == LAT_CYC - 1) begin
          m_done = 1; m_busy = 0; m_data = m_pend_data; m_neg = m_pend_neg; age = -1;
        end
      end else if (bus.start) begin
        dv = int'(bus.a_data) - int'(bus.b_data);
`ifdef SUB_ABS_EN
        m_pend_data = CALC_RES_W'(dv < 0 ? -dv : dv);
`else
        m_pend_data = CALC_RES_W'(dv);
`endif
        m_pend_neg = (dv < 0);
        age = 0;
        m_busy = 1;
      end
    end
    #1;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("sub_data", 32'(bus.sub_data), 32'(m_data));
    chk("done_and_busy", 32'(bus.done & bus.busy), 32'd0);
`ifdef SUB_ABS_EN
    chk("neg", 32'(bus.neg), 32'(m_neg));
`endif
  end

  // ---------------- directed stimulus ----------------
  // Counts negedges until done; start drops after cycle 1 unless held, in
  // which case operands are scrambled mid-operation.
  task automatic wait_done(input bit hold, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (!hold && cyc == 1) bus.start = 1'b0;
      if (hold && cyc == 2) begin
        bus.a_data = 4'd12;
        bus.b_data = 4'd0;
      end
    end while (!bus.done && cyc < 20);
    if (hold) bus.start = 1'b0;
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string name, input logic [5:0] lit_def,
                              input logic [5:0] lit_abs, input logic lit_neg);
`ifdef SUB_ABS_EN
    chk(name, 32'(bus.sub_data), 32'(lit_abs));
    chk({name, "_neg"}, 32'(bus.neg), 32'(lit_neg));
`else
    chk(name, 32'(bus.sub_data), 32'(lit_def));
    if (lit_neg) chk({name, "_sign"}, 32'(bus.sub_data[5]), 32'd1);
    if (lit_abs == 6'h3f) chk({name, "_abs"}, 32'(bus.sub_data), 32'd0);
`endif
  endtask

  task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic [5:0] lit_def, input logic [5:0] lit_abs, input logic lit_neg);
    int cyc;
    bus.start = 1'b1; bus.a_data = a; bus.b_data = b;
    wait_done(1'b0, cyc);
    chk({name, "_lat"}, 32'(cyc), 32'(LAT_CYC));
    check_result(name, lit_def, lit_abs, lit_neg);
  endtask

  initial begin
    int cyc;
    int dcnt;
    RST = 1'b1;
    bus.start = 1'b0; bus.a_data = '0; bus.b_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_data", 32'(bus.sub_data), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_op("9m3",  4'd9,  4'd3,  6'b000110, 6'b000110, 1'b0);
    run_op("3m9",  4'd3,  4'd9,  6'b111010, 6'b000110, 1'b1);
    run_op("0m15", 4'd0,  4'd15, 6'b110001, 6'b001111, 1'b1);
    run_op("15m0", 4'd15, 4'd0,  6'b001111, 6'b001111, 1'b0);
    run_op("7m7",  4'd7,  4'd7,  6'b000000, 6'b000000, 1'b0);
    repeat (2) @(negedge CLK);

    // start held through the operation with operands changing
    bus.start = 1'b1; bus.a_data = 4'd5; bus.b_data = 4'd2;
    wait_done(1'b1, cyc);
    chk("hold_lat", 32'(cyc), 32'(LAT_CYC));
    check_result("hold", 6'b000011, 6'b000011, 1'b0);
    dcnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.done) dcnt++;
    end
    chk("hold_extra_done", 32'(dcnt), 32'd0);

    // reset in cycle 2 of an operation
    bus.start = 1'b1; bus.a_data = 4'd9; bus.b_data = 4'd3;
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_data", 32'(bus.sub_data), 32'd0);
    RST = 1'b0;
    dcnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.done) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);

    // back-to-back: new start in the DONE cycle
    run_op("b2b_first", 4'd9, 4'd3, 6'b000110, 6'b000110, 1'b0);
    bus.start = 1'b1; bus.a_data = 4'd1; bus.b_data = 4'd2;
    wait_done(1'b0, cyc);
    chk("b2b_lat", 32'(cyc), 32'(LAT_CYC));
    check_result("b2b_1m2", 6'b111111, 6'b000001, 1'b1);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
